// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: controller state
// encodings and the signed-overflow rule for subtraction.
package serial_subtractor_pkg;

  // Controller states; a later serial_adder reuses the same encodings.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Two's-complement subtraction overflows when the operands have different
  // signs and the result sign differs from the minuend sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when a borrow is needed.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out for a single bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~a & bin) | (b & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin over WIDTH clocks, LSB first,
// using one full_subtractor cell and a borrow flop.
//
// Handshake: start is accepted at a rising edge only while busy=0 (IDLE);
// a, b and bin are captured at that edge and ignored afterwards. busy is high
// for exactly WIDTH cycles; done pulses for one cycle in the cycle diff, bout
// and ovf take their new values. Outputs hold until the next completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_done;

  logic             w_cell_d;
  logic             w_cell_bout;
  logic [WIDTH-1:0] w_d_next;

  full_subtractor u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_cell_d),
    .bout (w_cell_bout)
  );

  // New difference bit enters at the MSB so bit 0 ends up at position 0.
  assign w_d_next = {w_cell_d, r_d_sh[WIDTH-1:1]};

  // State register; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: accept in IDLE, leave RUN on the last bit.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands, shift one bit per RUN cycle, publish results
  // only on the final bit so outputs never show partial values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a_sh   <= a;
        r_b_sh   <= b;
        r_borrow <= bin;
        r_cnt    <= '0;
        r_a_msb  <= a[WIDTH-1];
        r_b_msb  <= b[WIDTH-1];
      end else if (r_state == S_RUN) begin
        r_a_sh   <= r_a_sh >> 1;
        r_b_sh   <= r_b_sh >> 1;
        r_d_sh   <= w_d_next;
        r_borrow <= w_cell_bout;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_diff <= w_d_next;
          r_bout <= w_cell_bout;
          r_ovf  <= sub_ovf(r_a_msb, r_b_msb, w_cell_d);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign done      = r_done;
  assign busy      = (r_state == S_RUN);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for handshake,
// timing and corner cases, and a 4-bit instance swept over every operand set.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT: WIDTH=8 ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic [7:0] diff8;
  logic       bout8, ovf8, busy8, done8;
  state_t     dbg8;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .bout(bout8), .ovf(ovf8), .busy(busy8), .done(done8),
    .dbg_state(dbg8)
  );

  // ---------------- DUT: WIDTH=4 ----------------
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic [3:0] diff4;
  logic       bout4, ovf4, busy4, done4;
  state_t     dbg4;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .diff(diff4), .bout(bout4), .ovf(ovf4), .busy(busy4), .done(done4),
    .dbg_state(dbg4)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: request one operation and wait (bounded) for done.
  // lat = edges from accept to done (-1 on timeout); bcnt = busy cycles seen.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     output int lat, output int bcnt);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    lat = -1; bcnt = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 1) start8 = 1'b0;
      if (done8) begin lat = j - 1; break; end
      if (busy8) bcnt++;
    end
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                     output int lat);
    a4 = ta; b4 = tb; bin4 = tbin; start4 = 1'b1;
    lat = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) start4 = 1'b0;
      if (done4) begin lat = j - 1; break; end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, bcnt, g, ndone, full;
    logic [3:0] ea, eb, ed;
    logic eb_in;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_diff", diff8, 8'h00);
    chk("rst_bout", bout8, 1'b0);
    chk("rst_ovf", ovf8, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_state", dbg8, S_IDLE);
    chk("rst_busy4", busy4, 1'b0);

    // 100 - 37 = 63, latency and busy width
    op8(8'd100, 8'd37, 1'b0, lat, bcnt);
    chk("t1_lat", lat, 8);
    chk("t1_busy_cycles", bcnt, 8);
    chk("t1_diff", diff8, 8'd63);
    chk("t1_bout", bout8, 1'b0);
    chk("t1_ovf", ovf8, 1'b0);
    @(negedge clk);
    chk("t1_done_width", done8, 1'b0);
    chk("t1_hold", diff8, 8'd63);

    // 0 - 1 and 0 - 0 - 1
    op8(8'h00, 8'h01, 1'b0, lat, bcnt);
    chk("t2_diff", diff8, 8'hFF);
    chk("t2_bout", bout8, 1'b1);
    chk("t2_ovf", ovf8, 1'b0);
    op8(8'h00, 8'h00, 1'b1, lat, bcnt);
    chk("t3_diff", diff8, 8'hFF);
    chk("t3_bout", bout8, 1'b1);
    chk("t3_ovf", ovf8, 1'b0);

    // Signed overflow both directions
    op8(8'h80, 8'h01, 1'b0, lat, bcnt);
    chk("t4_diff", diff8, 8'h7F);
    chk("t4_bout", bout8, 1'b0);
    chk("t4_ovf", ovf8, 1'b1);
    op8(8'h7F, 8'hFF, 1'b0, lat, bcnt);
    chk("t5_diff", diff8, 8'h80);
    chk("t5_bout", bout8, 1'b1);
    chk("t5_ovf", ovf8, 1'b1);

    // 50 - 20 with a second start while busy (9 - 9) that must be ignored
    a8 = 8'd50; b8 = 8'd20; bin8 = 1'b0; start8 = 1'b1;
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 1) begin start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; end
      if (j == 3) begin start8 = 1'b1; a8 = 8'd9; b8 = 8'd9; end
      if (j == 4) begin
        start8 = 1'b0; a8 = 8'h13; b8 = 8'hC4; bin8 = 1'b1;
        chk("t6_hold_midrun", diff8, 8'h80);
      end
      if (done8) begin lat = j - 1; break; end
    end
    bin8 = 1'b0;
    chk("t6_lat", lat, 8);
    chk("t6_diff", diff8, 8'd30);
    chk("t6_bout", bout8, 1'b0);
    // The ignored request must not have started a second operation
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("t6_no_extra_done", ndone, 0);

    // Start held high: back-to-back results every 9 cycles
    op8(8'd50, 8'd20, 1'b0, lat, bcnt);
    // op8 dropped start after the first edge; re-raise for held behaviour
    chk("t7a_diff", diff8, 8'd30);
    a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;  // accepted at the next edge (IDLE)
    g = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done8) begin g = j; break; end
    end
    // done after 8 edges; start stays high so the next accept is immediate
    chk("t7b_lat", g - 1, 8);
    chk("t7b_diff", diff8, 8'd7);
    a8 = 8'd200; b8 = 8'd55;
    g = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 1) start8 = 1'b0;
      if (done8) begin g = j; break; end
    end
    chk("t7_done_period", g, 9);
    chk("t7c_diff", diff8, 8'h91);
    chk("t7c_bout", bout8, 1'b0);
    chk("t7c_ovf", ovf8, 1'b0);

    // Reset during the 4th RUN cycle aborts with no done
    a8 = 8'd100; b8 = 8'd37; bin8 = 1'b0; start8 = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) start8 = 1'b0;
    end
    chk("t8_busy_before_rst", busy8, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t8_diff", diff8, 8'h00);
    chk("t8_bout", bout8, 1'b0);
    chk("t8_ovf", ovf8, 1'b0);
    chk("t8_busy", busy8, 1'b0);
    chk("t8_done", done8, 1'b0);
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("t8_no_done", ndone, 0);
    op8(8'd5, 8'd3, 1'b0, lat, bcnt);
    chk("t9_lat", lat, 8);
    chk("t9_diff", diff8, 8'd2);
    chk("t9_bout", bout8, 1'b0);

    // WIDTH=4 exhaustive sweep against an integer model
    for (int x = 0; x < 512; x++) begin
      ea = x[8:5]; eb = x[4:1]; eb_in = x[0];
      full = int'(ea) - int'(eb) - int'(eb_in);
      ed = full[3:0];
      op4(ea, eb, eb_in, lat);
      chk($sformatf("w4_lat_%0d", x), lat, 4);
      chk($sformatf("w4_diff_%0d", x), diff4, ed);
      chk($sformatf("w4_bout_%0d", x), bout4, (full < 0));
      chk($sformatf("w4_ovf_%0d", x), ovf4, (ea[3] != eb[3]) && (ed[3] != ea[3]));
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
